// File: rtl/noc_flit_packetizer.sv
// NoC injection stage: accepts a whole message, slices it into framed flits and
// emits them one per cycle under credit-based flow control toward the router.
module noc_flit_packetizer #(
  parameter int unsigned NOC_WIDTH  = 600,
  parameter int unsigned DEST_WIDTH = 4,
  parameter int unsigned MAX_FLITS  = 4,
  parameter int unsigned CREDITS    = 8,
  localparam int unsigned FDW   = NOC_WIDTH - 3 - DEST_WIDTH,
  localparam int unsigned MSG_W = MAX_FLITS * FDW,
  localparam int unsigned LW    = $clog2(MAX_FLITS + 1),
  localparam int unsigned CW    = $clog2(CREDITS + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [MSG_W-1:0]      in_data,
  input  logic [LW-1:0]         in_len,
  input  logic [DEST_WIDTH-1:0] in_dest,
  output logic [NOC_WIDTH-1:0]  flit_out,
  input  logic                  credit_in,
  output logic [CW-1:0]         credits,
  output logic [31:0]           pkt_count,
  output logic                  credit_err
);

  localparam logic [LW-1:0] MaxLen  = LW'(MAX_FLITS);
  localparam logic [CW-1:0] CredMax = CW'(CREDITS);

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  state_e                state_q, state_d;
  logic [MSG_W-1:0]      data_q, data_d;
  logic [LW-1:0]         rem_q, rem_d;
  logic                  head_q, head_d;
  logic [DEST_WIDTH-1:0] dest_q, dest_d;
  logic [NOC_WIDTH-1:0]  flit_q, flit_d;
  logic [CW-1:0]         cred_q, cred_d;
  logic [31:0]           pkt_q, pkt_d;
  logic                  err_q, err_d;

  logic          accept;
  logic          send;
  logic          tail;
  logic [LW-1:0] len_norm;

  assign in_ready   = (state_q == StIdle);
  assign accept     = in_valid & in_ready;
  assign send       = (state_q == StSend) && (cred_q != '0);
  assign tail       = (rem_q == LW'(1));
  assign flit_out   = flit_q;
  assign credits    = cred_q;
  assign pkt_count  = pkt_q;
  assign credit_err = err_q;

  always_comb begin
    len_norm = in_len;
    if (in_len == '0) begin
      len_norm = LW'(1);
    end else if (in_len > MaxLen) begin
      len_norm = MaxLen;
    end
  end

  // Payload is kept as a shift register so the current flit is always the low slice.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    rem_d   = rem_q;
    head_d  = head_q;
    dest_d  = dest_q;
    pkt_d   = pkt_q;
    flit_d  = flit_q;
    flit_d[NOC_WIDTH-1] = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          data_d  = in_data;
          rem_d   = len_norm;
          head_d  = 1'b1;
          dest_d  = in_dest;
          state_d = StSend;
        end
      end
      StSend: begin
        if (send) begin
          flit_d = {1'b1, head_q, tail, dest_q, data_q[FDW-1:0]};
          data_d = data_q >> FDW;
          rem_d  = rem_q - LW'(1);
          head_d = 1'b0;
          if (tail) begin
            pkt_d   = pkt_q + 32'd1;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Send and return in the same cycle cancel; an excess return saturates and is flagged.
  always_comb begin
    cred_d = cred_q;
    err_d  = err_q;
    if (send && !credit_in) begin
      cred_d = cred_q - CW'(1);
    end else if (!send && credit_in) begin
      if (cred_q == CredMax) begin
        err_d = 1'b1;
      end else begin
        cred_d = cred_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      data_q  <= '0;
      rem_q   <= '0;
      head_q  <= 1'b0;
      dest_q  <= '0;
      flit_q  <= '0;
      cred_q  <= CredMax;
      pkt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      rem_q   <= rem_d;
      head_q  <= head_d;
      dest_q  <= dest_d;
      flit_q  <= flit_d;
      cred_q  <= cred_d;
      pkt_q   <= pkt_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_noc_flit_packetizer.sv
// Bench for noc_flit_packetizer: directed and random messages checked against a
// queue-of-expected-flits reference model with a credit counter.
module tb_noc_flit_packetizer;

  localparam int NW    = 600;
  localparam int DW    = 4;
  localparam int MAXF  = 4;
  localparam int CRED  = 8;
  localparam int FDW   = NW - 3 - DW;
  localparam int MSG_W = MAXF * FDW;
  localparam int LW    = $clog2(MAXF + 1);
  localparam int CW    = $clog2(CRED + 1);

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [MSG_W-1:0] in_data;
  logic [LW-1:0]    in_len;
  logic [DW-1:0]    in_dest;
  logic [NW-1:0]    flit_out;
  logic             credit_in;
  logic [CW-1:0]    credits;
  logic [31:0]      pkt_count;
  logic             credit_err;

  noc_flit_packetizer #(
    .NOC_WIDTH (NW),
    .DEST_WIDTH(DW),
    .MAX_FLITS (MAXF),
    .CREDITS   (CRED)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_len    (in_len),
    .in_dest   (in_dest),
    .flit_out  (flit_out),
    .credit_in (credit_in),
    .credits   (credits),
    .pkt_count (pkt_count),
    .credit_err(credit_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: flits still owed to the router, last emitted flit, counters.
  logic [NW-1:0] m_q[$];
  logic [NW-1:0] m_flit;
  int            m_cred;
  int            m_pkt;
  logic          m_err;

  task automatic check(input string tag, input logic [NW-1:0] obs, input logic [NW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_flit = '0;
    m_cred = CRED;
    m_pkt  = 0;
    m_err  = 1'b0;
  endtask

  function automatic logic [MSG_W-1:0] rand_msg();
    logic [MSG_W-1:0] r;
    r = '0;
    for (int i = 0; i <= MSG_W / 32; i++) r = (r << 32) | MSG_W'($urandom());
    return r;
  endfunction

  // One clock: drive inputs, predict from the message-level model, compare after the edge.
  task automatic cycle(input logic v, input logic [LW-1:0] len, input logic [DW-1:0] dest,
                       input logic [MSG_W-1:0] data, input logic cin);
    bit            acc;
    bit            snd;
    int            n;
    int            nc;
    logic [NW-1:0] f;
    in_valid  = v;
    in_len    = len;
    in_dest   = dest;
    in_data   = data;
    credit_in = cin;
    check("in_ready", NW'(in_ready), NW'(m_q.size() == 0));
    acc = v && (m_q.size() == 0);
    snd = (m_q.size() > 0) && (m_cred > 0);
    @(posedge clk);
    #1;
    if (snd) begin
      m_flit = m_q.pop_front();
      if (m_flit[NW-3]) m_pkt++;
    end else begin
      m_flit[NW-1] = 1'b0;
    end
    nc = m_cred - (snd ? 1 : 0) + (cin ? 1 : 0);
    if (nc > CRED) begin
      nc    = CRED;
      m_err = 1'b1;
    end
    m_cred = nc;
    if (acc) begin
      n = (len == 0) ? 1 : ((len > MAXF) ? MAXF : int'(len));
      for (int k = 0; k < n; k++) begin
        f = {1'b1, (k == 0), (k == n - 1), dest, data[k*FDW +: FDW]};
        m_q.push_back(f);
      end
    end
    check("flit_out", flit_out, m_flit);
    check("credits", NW'(credits), NW'(m_cred));
    check("pkt_count", NW'(pkt_count), NW'(m_pkt));
    check("credit_err", NW'(credit_err), NW'(m_err));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, '0, 1'b0);
  endtask

  task automatic refill();
    for (int i = 0; i < CRED && m_cred < CRED; i++) cycle(1'b0, '0, '0, '0, 1'b1);
  endtask

  task automatic check_reset_values();
    check("rst_flit", flit_out, '0);
    check("rst_credits", NW'(credits), NW'(CRED));
    check("rst_pkt", NW'(pkt_count), '0);
    check("rst_err", NW'(credit_err), '0);
  endtask

  initial begin
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_len    = '0;
    in_dest   = '0;
    credit_in = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_values();
    check("rst_ready", NW'(in_ready), NW'(1));
    rst = 1'b1;
    idle(2);

    // Single flit, dest 5, data 0xABC.
    cycle(1'b1, LW'(1), DW'(5), MSG_W'(12'hABC), 1'b0);
    cycle(1'b0, '0, '0, '0, 1'b0);
    check("single_flit", flit_out, {1'b1, 1'b1, 1'b1, DW'(5), FDW'(12'hABC)});
    idle(2);
    refill();

    // Four flits from full credits, then the credit-stall scenario.
    cycle(1'b1, LW'(4), DW'(3), rand_msg(), 1'b0);
    idle(5);
    check("four_credits", NW'(credits), NW'(4));
    refill();
    cycle(1'b1, LW'(4), DW'(9), rand_msg(), 1'b0);
    idle(4);
    cycle(1'b1, LW'(4), DW'(10), rand_msg(), 1'b0);
    idle(4);
    cycle(1'b1, LW'(4), DW'(11), rand_msg(), 1'b0);
    idle(4);
    check("stall_credits", NW'(credits), '0);
    cycle(1'b0, '0, '0, '0, 1'b1);
    idle(3);
    refill();
    idle(4);
    refill();

    // Credit return while sending; excess return while idle.
    cycle(1'b1, LW'(3), DW'(7), rand_msg(), 1'b0);
    cycle(1'b0, '0, '0, '0, 1'b1);
    cycle(1'b0, '0, '0, '0, 1'b1);
    idle(3);
    refill();
    cycle(1'b0, '0, '0, '0, 1'b1);
    check("excess_err", NW'(credit_err), NW'(1));

    // Length edge cases.
    cycle(1'b1, LW'(0), DW'(2), rand_msg(), 1'b0);
    idle(2);
    cycle(1'b1, LW'(7), DW'(14), rand_msg(), 1'b1);
    idle(6);
    refill();

    // Random traffic; inputs change freely while the packetizer is busy.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 2) == 0), LW'($urandom_range(0, 7)), DW'($urandom()),
            rand_msg(), ($urandom_range(0, 9) < 4));
    end

    // Reset in the middle of a packet: nothing more of it may appear.
    refill();
    cycle(1'b1, LW'(4), DW'(6), rand_msg(), 1'b0);
    cycle(1'b0, '0, '0, '0, 1'b0);
    in_valid  = 1'b0;
    credit_in = 1'b0;
    rst       = 1'b0;
    #1;
    model_reset();
    check_reset_values();
    @(posedge clk);
    #1;
    check("rst_hold_flit", flit_out, '0);
    rst = 1'b1;
    #1;
    check("rst_release_ready", NW'(in_ready), NW'(1));
    idle(3);
    cycle(1'b1, LW'(2), DW'(1), rand_msg(), 1'b0);
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
